// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - pitch frequency table, note field widths and sequencer states
package tone_pkg;

  localparam int PITCH_W   = 5;
  localparam int NUM_PITCH = 24;

  localparam logic [PITCH_W-1:0] PITCH_REST = 5'd0;
  localparam int                 PITCH_LO   = 1;
  localparam int                 PITCH_HI   = 24;

  // C4..B5 chromatic, rounded to whole Hz
  localparam int FREQ_HZ [NUM_PITCH] = '{
    262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
    523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_DONE
  } state_t;

  // Zero marks a rest code; the tone generator holds its output low for it
  function automatic int half_cycles(input int clk_hz, input int p);
    int h;
    if (p < PITCH_LO || p > PITCH_HI) h = 0;
    else h = clk_hz / (2 * FREQ_HZ[p - PITCH_LO]);
    return h;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - half-period divider with enable producing the note square wave
module tone_gen #(
  parameter int HW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [HW-1:0] half,
  output logic          wave
);

  logic [HW-1:0] cnt;

  // Disabled or rest: restart so the next note begins low with a fresh count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (!en || half == '0) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (cnt == half - 1'b1) begin
      cnt  <= '0;
      wave <= ~wave;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// rtl/buzzer_sequencer.sv - loadable melody sequencer driving a square-wave buzzer
module buzzer_sequencer
  import tone_pkg::*;
#(
  parameter int  CLK_HZ  = 100_000_000,
  parameter int  TICK_HZ = 16,
  parameter int  DEPTH   = 64,
  parameter int  DUR_W   = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [PITCH_W+DUR_W-1:0] wr_data,
  input  logic [AW:0]              len,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     mute,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            note_idx,
  output logic                     beep
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int TW       = $clog2(TICK_CYC + 1);
  localparam int NW       = PITCH_W + DUR_W;
  localparam int HW       = $clog2(CLK_HZ / (2 * FREQ_HZ[0]) + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

  state_t              state, state_n;
  logic   [AW-1:0]     idx_n;
  logic   [AW:0]       len_q;
  logic                len_ld;
  logic   [NW-1:0]     mem [DEPTH];
  logic   [NW-1:0]     note_q;
  logic   [TW-1:0]     tick_cnt;
  logic   [DUR_W-1:0]  dur_cnt;
  logic                note_end;
  logic                wave;
  logic   [HW-1:0]     half_tab [32];

  for (genvar g = 0; g < 32; g++) begin : g_half
    assign half_tab[g] = HW'(half_cycles(CLK_HZ, g));
  end

  // Read register only loads in FETCH, so later writes cannot alter the playing note
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (state == ST_FETCH) note_q <= mem[note_idx];
  end

  assign note_end = (tick_cnt == TICK_LAST) && (dur_cnt == note_q[DUR_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      note_idx <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      if (len_ld) len_q <= len;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    len_ld  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          len_ld = 1'b1;
          if (len == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_FETCH;
            idx_n   = '0;
          end
        end
      end
      ST_FETCH: state_n = stop ? ST_IDLE : ST_PLAY;
      ST_PLAY: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (note_end) begin
          if ({1'b0, note_idx} == len_q - 1'b1) begin
            if (loop) begin
              state_n = ST_FETCH;
              idx_n   = '0;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
            state_n = ST_FETCH;
            idx_n   = note_idx + 1'b1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (state != ST_PLAY) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      dur_cnt  <= dur_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  tone_gen #(.HW(HW)) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (state == ST_PLAY),
    .half (half_tab[note_q[NW-1:DUR_W]]),
    .wave (wave)
  );

  assign busy = (state == ST_FETCH) || (state == ST_PLAY);
  assign done = (state == ST_DONE);
  assign beep = wave && (state == ST_PLAY) && !mute;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb/tb_buzzer_sequencer.sv - directed scoreboard bench for buzzer_sequencer
module tb_buzzer_sequencer;

  localparam int CLK_HZ  = 1_000_000;
  localparam int TICK_HZ = 1000;
  localparam int DEPTH   = 64;
  localparam int DUR_W   = 4;
  localparam int AW      = 6;
  localparam int NW      = 5 + DUR_W;
  localparam int H_A4    = CLK_HZ / (2 * 440);
  localparam int H_C4    = CLK_HZ / (2 * 262);
  localparam int H_B5    = CLK_HZ / (2 * 988);
  localparam int NMAX    = 12000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NW-1:0] wr_data;
  logic [AW:0]   len;
  logic          start, stop, loop, mute;
  logic          busy, done, beep;
  logic [AW-1:0] note_idx;

  buzzer_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DEPTH  (DEPTH),
    .DUR_W  (DUR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .len     (len),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .mute    (mute),
    .busy    (busy),
    .done    (done),
    .note_idx(note_idx),
    .beep    (beep)
  );

  always #5 clk = ~clk;

  logic          beep_s [NMAX];
  logic          busy_s [NMAX];
  logic          done_s [NMAX];
  logic [AW-1:0] idx_s  [NMAX];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic sample(input int c);
    beep_s[c] = beep;
    busy_s[c] = busy;
    done_s[c] = done;
    idx_s[c]  = note_idx;
  endtask

  task automatic rec(input int n);
    for (int c = 0; c < n; c++) begin
      sample(c);
      @(negedge clk);
    end
  endtask

  task automatic write_note(input int addr, input int pitch, input int dur);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {5'(pitch), 4'(dur)};
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic start_play(input int l, input logic lp);
    len   = 7'(l);
    loop  = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int first_edge(input int from, input int to, input logic v);
    int lo = (from < 1) ? 1 : from;
    for (int c = lo; c <= to; c++)
      if (beep_s[c] === v && beep_s[c-1] !== v) return c;
    return -1;
  endfunction

  function automatic int count(input int sel, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) begin
      if (sel == 0 && beep_s[c] === 1'b1) n++;
      if (sel == 1 && busy_s[c] === 1'b1) n++;
      if (sel == 2 && done_s[c] === 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycle budget exhausted observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; mute = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push(0); push(0); push(0); push(0);
    @(negedge clk);
    check("rst_busy", busy);
    check("rst_done", done);
    check("rst_idx", note_idx);
    check("rst_beep", beep);

    // single A4 note, two ticks
    write_note(0, 10, 1);
    start_play(1, 1'b0);
    push(1); push(2001); push(H_A4); push(1); push(1); push(0); push(0); push(0);
    rec(2100);
    check("t1_busy_fetch", busy_s[0]);
    check("t1_busy_cycles", count(1, 0, 2099));
    check("t1_first_rise", first_edge(1, 2099, 1'b1) - 1);
    check("t1_done_count", count(2, 0, 2099));
    check("t1_done_at", done_s[2001]);
    check("t1_busy_in_done", busy_s[2001]);
    check("t1_idle_busy", busy_s[2002]);
    check("t1_idle_done", done_s[2002]);

    // three-note tune, no loop
    write_note(0, 1, 3);
    write_note(1, 0, 0);
    write_note(2, 24, 3);
    start_play(3, 1'b0);
    push(0); push(0); push(1); push(2); push(H_C4); push(H_C4); push(0); push(1);
    push(H_B5); push(H_B5); push(1); push(0); push(1); push(0); push(1); push(0);
    rec(9010);
    check("t2_idx_mid0", idx_s[2000]);
    check("t2_idx_end0", idx_s[4000]);
    check("t2_idx_fetch1", idx_s[4001]);
    check("t2_idx_fetch2", idx_s[5002]);
    r = first_edge(1, 4000, 1'b1);
    check("t2_c4_rise", r - 1);
    f = first_edge(r + 1, 4000, 1'b0);
    check("t2_c4_half", f - r);
    check("t2_rest_silent", count(0, 4002, 5001));
    check("t2_busy_gap", busy_s[4001]);
    r = first_edge(5003, 9002, 1'b1);
    check("t2_b5_rise", r - 5003);
    f = first_edge(r + 1, 9002, 1'b0);
    check("t2_b5_half", f - r);
    check("t2_beep_last", beep_s[9002]);
    check("t2_beep_done", beep_s[9003]);
    check("t2_done_at", done_s[9003]);
    check("t2_busy_done", busy_s[9003]);
    check("t2_done_count", count(2, 0, 9009));
    check("t2_idle_busy", busy_s[9004]);

    // looping, then stop mid-note
    start_play(3, 1'b1);
    push(2); push(0); push(1); push(0); push(1); push(0); push(0); push(H_C4);
    push(11600); push(1); push(0); push(0); push(0); push(0);
    rec(11600);
    check("t3_idx_last", idx_s[9002]);
    check("t3_idx_wrap", idx_s[9003]);
    check("t3_busy_wrap", busy_s[9003]);
    check("t3_beep_gap", beep_s[9003]);
    check("t3_beep_pre_gap", beep_s[9002]);
    check("t3_beep_entry", beep_s[9004]);
    check("t3_no_done", count(2, 0, 11599));
    check("t3_c4_rise_loop", first_edge(9004, 11599, 1'b1) - 9004);
    check("t3_busy_all", count(1, 0, 11599));
    check("t3_beep_live", beep);
    check("t3_idx_live", note_idx);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop = 1'b0;
    check("t3_stop_busy", busy);
    check("t3_stop_beep", beep);
    @(negedge clk);
    check("t3_stop_no_done", done);

    // start with stop from IDLE, then zero-length start
    push(0); push(0); push(0); push(1); push(0); push(0); push(0);
    len = 7'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("t4_ss_busy", busy);
    @(negedge clk);
    check("t4_ss_busy2", busy);
    check("t4_ss_done", done);
    start_play(0, 1'b0);
    check("t4_len0_done", done);
    check("t4_len0_busy", busy);
    @(negedge clk);
    check("t4_len0_done_off", done);
    check("t4_len0_busy_off", busy);

    // mute over the A4 rising edge, restart attempt while busy
    write_note(0, 10, 1);
    start_play(1, 1'b0);
    push(0); push(1); push(0); push(1); push(1); push(1);
    for (int c = 0; c < 2100; c++) begin
      sample(c);
      if (c == 500)  start = 1'b1;
      if (c == 501)  start = 1'b0;
      if (c == 1099) mute  = 1'b1;
      if (c == 1399) mute  = 1'b0;
      @(negedge clk);
    end
    check("t5_muted_beep", count(0, 1100, 1399));
    check("t5_unmuted_beep", beep_s[1400]);
    check("t5_idx", idx_s[1000]);
    check("t5_busy_end", busy_s[2000]);
    check("t5_done_at", done_s[2001]);
    check("t5_done_count", count(2, 0, 2099));

    // asynchronous reset during the third note
    start_play(3, 1'b0);
    push(1); push(2); push(1); push(0); push(0); push(0); push(0);
    rec(4000);
    check("t6_beep_pre", beep);
    check("t6_idx_pre", note_idx);
    check("t6_busy_pre", busy);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy);
    check("t6_rst_beep", beep);
    check("t6_rst_idx", note_idx);
    check("t6_rst_done", done);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_play(1, 1'b0);
    push(1); push(0); push(H_A4);
    rec(1200);
    check("t6_restart_busy", busy_s[0]);
    check("t6_restart_idx", idx_s[0]);
    check("t6_restart_rise", first_edge(1, 1199, 1'b1) - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
